// File: rtl/sprite_pkg.sv
// Shared sprite definitions: attribute bit-field positions, entry count and
// the line-scanner state encoding. Used by the attribute write side, the
// line scanner and the renderer.
package sprite_pkg;

    localparam int SPRITE_COUNT = 128;

    // Attribute word 2n
    localparam int ADDR_LSB   = 0;
    localparam int ADDR_W     = 12;
    localparam int MODE_BIT   = 15;
    localparam int X_LSB      = 16;
    localparam int X_W        = 10;

    // Attribute word 2n+1
    localparam int Y_LSB      = 0;
    localparam int Y_W        = 10;
    localparam int HFLIP_BIT  = 16;
    localparam int VFLIP_BIT  = 17;
    localparam int Z_LSB      = 18;
    localparam int Z_W        = 2;
    localparam int COLL_LSB   = 20;
    localparam int COLL_W     = 4;
    localparam int PAL_LSB    = 24;
    localparam int PAL_W      = 4;
    localparam int WIDTH_LSB  = 28;
    localparam int HEIGHT_LSB = 30;
    localparam int SIZE_W     = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        CHK,
        RD0,
        EMIT,
        DONE
    } scan_state_e;

    // RAM word address of attribute word 'word' (0 or 1) of sprite 'idx'
    function automatic logic [7:0] attr_addr(input logic [6:0] idx, input logic word);
        return {idx, word};
    endfunction

endpackage

// File: rtl/sprite_line_hit.sv
// Vertical intersection test of one sprite against the display line:
// wraparound distance, hit decision and row-within-sprite with vflip.
module sprite_line_hit (
    input  logic [9:0] line_i,
    input  logic [9:0] y_i,
    input  logic [1:0] hcode_i,
    input  logic       vflip_i,
    input  logic [1:0] z_i,
    output logic       hit_o,
    output logic [5:0] row_o
);

    logic [9:0] d;
    logic [6:0] h;
    logic [5:0] hm1;

    // Height 8<<code, 10-bit wrapped distance; z==0 marks a disabled sprite
    always_comb begin
        h     = 7'd8 << hcode_i;
        hm1   = 6'((7'd8 << hcode_i) - 7'd1);
        d     = line_i - y_i;
        hit_o = (z_i != 2'd0) && (d < {3'b000, h});
        // On a hit d < h <= 64, so the low 6 bits hold the whole row
        row_o = vflip_i ? (hm1 - d[5:0]) : d[5:0];
    end

endmodule

// File: rtl/sprite_line_scanner.sv
// Walks the sprite attribute RAM at each line start and streams the sprites
// intersecting the requested line, in index order, to the renderer.
module sprite_line_scanner #(
    parameter int SPRITE_COUNT = 128,
    parameter int MAX_HITS     = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        sprites_enable_i,
    input  logic        line_start_i,
    input  logic [9:0]  line_i,
    output logic [7:0]  ram_rd_addr_o,
    output logic        ram_rd_en_o,
    input  logic [31:0] ram_rd_data_i,
    output logic        spr_valid_o,
    input  logic        spr_ready_i,
    output logic [6:0]  spr_index_o,
    output logic [9:0]  spr_x_o,
    output logic [11:0] spr_addr_o,
    output logic        spr_mode_o,
    output logic        spr_hflip_o,
    output logic [1:0]  spr_width_o,
    output logic [1:0]  spr_z_o,
    output logic [3:0]  spr_pal_o,
    output logic [3:0]  spr_coll_o,
    output logic [5:0]  spr_row_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o
);
    import sprite_pkg::*;

    localparam int IDX_W  = 7;
    localparam int HITS_W = $clog2(MAX_HITS + 1);

    scan_state_e         state_q, state_d;
    logic [IDX_W-1:0]    n_q, n_d;
    logic [HITS_W-1:0]   hits_q, hits_d;
    logic [9:0]          line_q, line_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic [6:0]          idx_q, idx_d;
    logic [9:0]          x_q, x_d;
    logic [11:0]         addr_q, addr_d;
    logic                mode_q, mode_d;
    logic                hflip_q, hflip_d;
    logic [1:0]          width_q, width_d;
    logic [1:0]          z_q, z_d;
    logic [3:0]          pal_q, pal_d;
    logic [3:0]          coll_q, coll_d;
    logic [5:0]          row_q, row_d;

    logic                start;
    logic                last;
    logic                hit;
    logic [5:0]          row_calc;
    logic                unused_bits;

    assign start       = line_start_i & sprites_enable_i;
    assign last        = (n_q == IDX_W'(SPRITE_COUNT - 1));
    assign unused_bits = ^ram_rd_data_i[14:12];

    sprite_line_hit u_hit (
        .line_i  (line_q),
        .y_i     (ram_rd_data_i[Y_LSB +: Y_W]),
        .hcode_i (ram_rd_data_i[HEIGHT_LSB +: SIZE_W]),
        .vflip_i (ram_rd_data_i[VFLIP_BIT]),
        .z_i     (ram_rd_data_i[Z_LSB +: Z_W]),
        .hit_o   (hit),
        .row_o   (row_calc)
    );

    // Next-state, RAM read strobes and record field capture
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        hits_d        = hits_q;
        line_d        = line_q;
        ovf_d         = ovf_q;
        valid_d       = valid_q;
        idx_d         = idx_q;
        x_d           = x_q;
        addr_d        = addr_q;
        mode_d        = mode_q;
        hflip_d       = hflip_q;
        width_d       = width_q;
        z_d           = z_q;
        pal_d         = pal_q;
        coll_d        = coll_q;
        row_d         = row_q;
        ram_rd_addr_o = 8'd0;
        ram_rd_en_o   = 1'b0;

        case (state_q)
            RD1: begin
                ram_rd_addr_o = attr_addr(n_q, 1'b1);
                ram_rd_en_o   = 1'b1;
                state_d       = CHK;
            end
            CHK: begin
                if (hit) begin
                    if (hits_q == HITS_W'(MAX_HITS)) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d         = n_q;
                        hflip_d       = ram_rd_data_i[HFLIP_BIT];
                        z_d           = ram_rd_data_i[Z_LSB +: Z_W];
                        pal_d         = ram_rd_data_i[PAL_LSB +: PAL_W];
                        coll_d        = ram_rd_data_i[COLL_LSB +: COLL_W];
                        width_d       = ram_rd_data_i[WIDTH_LSB +: SIZE_W];
                        row_d         = row_calc;
                        ram_rd_addr_o = attr_addr(n_q, 1'b0);
                        ram_rd_en_o   = 1'b1;
                        state_d       = RD0;
                    end
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = RD1;
                end
            end
            RD0: begin
                addr_d  = ram_rd_data_i[ADDR_LSB +: ADDR_W];
                mode_d  = ram_rd_data_i[MODE_BIT];
                x_d     = ram_rd_data_i[X_LSB +: X_W];
                valid_d = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (valid_q && spr_ready_i) begin
                    valid_d = 1'b0;
                    hits_d  = hits_q + 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        n_d     = n_q + 1'b1;
                        state_d = RD1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A line start in any state (re)starts the scan; a pending record is dropped
        if (start) begin
            state_d = RD1;
            n_d     = '0;
            hits_d  = '0;
            line_d  = line_i;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end
    end

    // State and record registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            hits_q  <= '0;
            line_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            x_q     <= '0;
            addr_q  <= '0;
            mode_q  <= 1'b0;
            hflip_q <= 1'b0;
            width_q <= '0;
            z_q     <= '0;
            pal_q   <= '0;
            coll_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            hits_q  <= hits_d;
            line_q  <= line_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            hflip_q <= hflip_d;
            width_q <= width_d;
            z_q     <= z_d;
            pal_q   <= pal_d;
            coll_q  <= coll_d;
            row_q   <= row_d;
        end
    end

    assign spr_valid_o = valid_q;
    assign spr_index_o = idx_q;
    assign spr_x_o     = x_q;
    assign spr_addr_o  = addr_q;
    assign spr_mode_o  = mode_q;
    assign spr_hflip_o = hflip_q;
    assign spr_width_o = width_q;
    assign spr_z_o     = z_q;
    assign spr_pal_o   = pal_q;
    assign spr_coll_o  = coll_q;
    assign spr_row_o   = row_q;
    assign overflow_o  = ovf_q;
    assign done_o      = (state_q == DONE);
    assign busy_o      = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner with a behavioural attribute RAM.
module tb_sprite_line_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sprites_enable;
    logic        line_start;
    logic [9:0]  line_in;
    logic [7:0]  ram_rd_addr;
    logic        ram_rd_en;
    logic [31:0] ram_rd_data = 32'd0;
    logic        spr_valid;
    logic        spr_ready;
    logic [6:0]  spr_index;
    logic [9:0]  spr_x;
    logic [11:0] spr_addr;
    logic        spr_mode;
    logic        spr_hflip;
    logic [1:0]  spr_width;
    logic [1:0]  spr_z;
    logic [3:0]  spr_pal;
    logic [3:0]  spr_coll;
    logic [5:0]  spr_row;
    logic        busy;
    logic        done;
    logic        overflow;

    logic [31:0] mem [256];
    int          cyc = 0;
    int          t0;
    int          n_cmp = 0;
    int          n_bad = 0;

    int          rec_idx[$];
    int          rec_row[$];
    int          rec_x[$];
    int          rec_addr[$];
    int          rec_misc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    sprite_line_scanner dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .sprites_enable_i (sprites_enable),
        .line_start_i     (line_start),
        .line_i           (line_in),
        .ram_rd_addr_o    (ram_rd_addr),
        .ram_rd_en_o      (ram_rd_en),
        .ram_rd_data_i    (ram_rd_data),
        .spr_valid_o      (spr_valid),
        .spr_ready_i      (spr_ready),
        .spr_index_o      (spr_index),
        .spr_x_o          (spr_x),
        .spr_addr_o       (spr_addr),
        .spr_mode_o       (spr_mode),
        .spr_hflip_o      (spr_hflip),
        .spr_width_o      (spr_width),
        .spr_z_o          (spr_z),
        .spr_pal_o        (spr_pal),
        .spr_coll_o       (spr_coll),
        .spr_row_o        (spr_row),
        .busy_o           (busy),
        .done_o           (done),
        .overflow_o       (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Attribute RAM: one-cycle registered read
    always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

    // Record and done-pulse collector, sampled on the inactive edge
    always @(negedge clk) begin
        if (spr_valid && spr_ready) begin
            rec_idx.push_back(int'(spr_index));
            rec_row.push_back(int'(spr_row));
            rec_x.push_back(int'(spr_x));
            rec_addr.push_back(int'(spr_addr));
            rec_misc.push_back(int'({spr_mode, spr_hflip, spr_width, spr_z, spr_pal, spr_coll}));
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic set_sprite(input int idx, input logic [9:0] x, input logic [11:0] a,
                              input logic mode, input logic [9:0] y, input logic hf,
                              input logic vf, input logic [1:0] z, input logic [3:0] pal,
                              input logic [3:0] coll, input logic [1:0] wc, input logic [1:0] hc);
        logic [31:0] w0, w1;
        w0 = 32'd0;
        w1 = 32'd0;
        w0[11:0]  = a;
        w0[15]    = mode;
        w0[25:16] = x;
        w1[9:0]   = y;
        w1[16]    = hf;
        w1[17]    = vf;
        w1[19:18] = z;
        w1[23:20] = coll;
        w1[27:24] = pal;
        w1[29:28] = wc;
        w1[31:30] = hc;
        mem[2*idx]   = w0;
        mem[2*idx+1] = w1;
    endtask

    // Pulse line_start for one cycle; t0 = cycle count just after the sampling edge
    task automatic start_scan(input logic [9:0] ln);
        @(posedge clk); #1;
        line_start = 1'b1;
        line_in    = ln;
        @(posedge clk); #1;
        t0         = cyc;
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int maxc, input string tag);
        int k = 0;
        while (done_cnt == base && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(tag, done_cnt != base, 1);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        int k = 0;
        @(negedge clk);
        while (!spr_valid && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(tag, spr_valid, 1);
    endtask

    initial begin
        int rb, db;
        rst_n          = 1'b0;
        sprites_enable = 1'b1;
        line_start     = 1'b0;
        line_in        = 10'd0;
        spr_ready      = 1'b1;
        clear_mem();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", spr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_rden", ram_rd_en, 0);
        chk("rst_rdaddr", ram_rd_addr, 0);
        chk("rst_index", spr_index, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Sprite 5: y=100, h=16, line 110 -> row 10
        set_sprite(5, 10'd200, 12'h123, 1'b1, 10'd100, 1'b1, 1'b0, 2'd3, 4'hA, 4'h6, 2'd2, 2'd1);
        rb = rec_idx.size(); db = done_cnt;
        start_scan(10'd110);
        @(negedge clk);
        chk("s5_busy", busy, 1);
        wait_done(db, 600, "s5_done_seen");
        chk("s5_count", rec_idx.size() - rb, 1);
        chk("s5_index", rec_idx[rb], 5);
        chk("s5_row", rec_row[rb], 10);
        chk("s5_x", rec_x[rb], 200);
        chk("s5_addr", rec_addr[rb], 32'h123);
        chk("s5_misc", rec_misc[rb], {1'b1, 1'b1, 2'd2, 2'd3, 4'hA, 4'h6});
        chk("s5_busy_end", busy, 0);
        chk("s5_ovf", overflow, 0);

        // Same sprite with vflip -> row 15-10 = 5
        set_sprite(5, 10'd200, 12'h123, 1'b1, 10'd100, 1'b1, 1'b1, 2'd3, 4'hA, 4'h6, 2'd2, 2'd1);
        rb = rec_idx.size(); db = done_cnt;
        start_scan(10'd110);
        wait_done(db, 600, "vf_done_seen");
        chk("vf_count", rec_idx.size() - rb, 1);
        chk("vf_row", rec_row[rb], 5);

        // Wraparound: y=1020, h=8; line 3 -> d=7 hit, line 4 -> d=8 miss
        clear_mem();
        set_sprite(9, 10'd17, 12'h045, 1'b0, 10'd1020, 1'b0, 1'b0, 2'd1, 4'h0, 4'h0, 2'd0, 2'd0);
        rb = rec_idx.size(); db = done_cnt;
        start_scan(10'd3);
        wait_done(db, 600, "wr3_done_seen");
        chk("wr3_count", rec_idx.size() - rb, 1);
        chk("wr3_index", rec_idx[rb], 9);
        chk("wr3_row", rec_row[rb], 7);
        rb = rec_idx.size(); db = done_cnt;
        start_scan(10'd4);
        wait_done(db, 600, "wr4_done_seen");
        chk("wr4_count", rec_idx.size() - rb, 0);

        // z=0 sprite covering the line: no record; all-miss scan timing
        clear_mem();
        set_sprite(6, 10'd5, 12'h001, 1'b0, 10'd100, 1'b0, 1'b0, 2'd0, 4'h1, 4'h1, 2'd0, 2'd3);
        rb = rec_idx.size(); db = done_cnt;
        start_scan(10'd110);
        wait_done(db, 600, "z0_done_seen");
        chk("z0_count", rec_idx.size() - rb, 0);
        chk("miss_scan_cycles", done_cyc - t0, 256);
        chk("z0_done_once", done_cnt - db, 1);

        // All 128 sprites hit line 0: first 64 emitted, then overflow
        for (int i = 0; i < 128; i++)
            set_sprite(i, 10'(i), 12'(i), 1'b0, 10'd0, 1'b0, 1'b0, 2'd1, 4'h0, 4'h0, 2'd0, 2'd0);
        rb = rec_idx.size(); db = done_cnt;
        start_scan(10'd0);
        wait_done(db, 2000, "all_done_seen");
        chk("all_count", rec_idx.size() - rb, 64);
        for (int i = 0; i < 64; i++)
            if (rb + i < rec_idx.size()) chk($sformatf("all_idx%0d", i), rec_idx[rb+i], i);
        chk("all_ovf", overflow, 1);
        chk("all_done_once", done_cnt - db, 1);

        // Backpressure: sprite 3 held 10 cycles, then sprite 7 follows
        clear_mem();
        set_sprite(3, 10'd11, 12'h0AA, 1'b0, 10'd48, 1'b0, 1'b0, 2'd1, 4'h2, 4'h3, 2'd0, 2'd0);
        set_sprite(7, 10'd500, 12'hFFF, 1'b1, 10'd40, 1'b1, 1'b0, 2'd2, 4'h9, 4'h5, 2'd3, 2'd1);
        spr_ready = 1'b0;
        rb = rec_idx.size(); db = done_cnt;
        start_scan(10'd50);
        chk("bp_ovf_cleared", overflow, 0);
        wait_valid(200, "bp_valid_seen");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold_valid%0d", i), spr_valid, 1);
            chk($sformatf("bp_hold_idx%0d", i), spr_index, 3);
            chk($sformatf("bp_hold_x%0d", i), spr_x, 11);
            if (i == 9) begin
                chk("bp_hold_addr", spr_addr, 32'h0AA);
                chk("bp_hold_row", spr_row, 2);
            end
            @(negedge clk);
        end
        spr_ready = 1'b1;
        wait_done(db, 600, "bp_done_seen");
        chk("bp_count", rec_idx.size() - rb, 2);
        chk("bp_first", rec_idx[rb], 3);
        chk("bp_second", rec_idx[rb+1], 7);
        chk("bp_second_row", rec_row[rb+1], 10);
        chk("bp_second_x", rec_x[rb+1], 500);
        chk("bp_second_misc", rec_misc[rb+1], {1'b1, 1'b1, 2'd3, 2'd2, 4'h9, 4'h5});

        // Abort: new line start while sprite 2 waits in EMIT
        clear_mem();
        set_sprite(2, 10'd1, 12'h002, 1'b0, 10'd20, 1'b0, 1'b0, 2'd1, 4'h0, 4'h0, 2'd0, 2'd0);
        set_sprite(4, 10'd33, 12'h004, 1'b0, 10'd96, 1'b0, 1'b0, 2'd1, 4'h0, 4'h0, 2'd0, 2'd0);
        spr_ready = 1'b0;
        rb = rec_idx.size(); db = done_cnt;
        start_scan(10'd20);
        wait_valid(200, "ab_valid_seen");
        chk("ab_pending_idx", spr_index, 2);
        start_scan(10'd100);
        @(negedge clk);
        chk("ab_valid_dropped", spr_valid, 0);
        chk("ab_busy", busy, 1);
        spr_ready = 1'b1;
        wait_done(db, 600, "ab_done_seen");
        chk("ab_count", rec_idx.size() - rb, 1);
        chk("ab_index", rec_idx[rb], 4);
        chk("ab_row", rec_row[rb], 4);
        chk("ab_done_once", done_cnt - db, 1);

        // Enable low: line start ignored
        sprites_enable = 1'b0;
        rb = rec_idx.size(); db = done_cnt;
        start_scan(10'd100);
        repeat (20) @(negedge clk);
        chk("en0_busy", busy, 0);
        chk("en0_records", rec_idx.size() - rb, 0);
        chk("en0_done", done_cnt - db, 0);

        // Enable dropped mid-scan: scan still completes
        sprites_enable = 1'b1;
        db = done_cnt;
        start_scan(10'd100);
        sprites_enable = 1'b0;
        wait_done(db, 600, "en_mid_done_seen");
        sprites_enable = 1'b1;

        // Asynchronous reset while a record is pending
        clear_mem();
        set_sprite(5, 10'd200, 12'h123, 1'b1, 10'd100, 1'b1, 1'b0, 2'd3, 4'hA, 4'h6, 2'd2, 2'd1);
        spr_ready = 1'b0;
        start_scan(10'd110);
        wait_valid(200, "rm_valid_seen");
        chk("rm_pre_idx", spr_index, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_valid", spr_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_index", spr_index, 0);
        chk("rm_x", spr_x, 0);
        chk("rm_row", spr_row, 0);
        chk("rm_rden", ram_rd_en, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        spr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rm_idle_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
